mole_scheduler: RTL and testbench
=================================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per game tick (10 ms at 100 MHz).
REQ-002 Parameter SPAWN_TICKS, default 50, ticks between spawn attempts.
REQ-003 Parameter LIFE_TICKS, default 80, ticks a mole stays up; range 1..255.
REQ-004 Parameter ROUND_TICKS, default 3000, ticks per round; range 1..4095.
REQ-005 Parameter MAX_ACTIVE, default 3, maximum moles up at once; range 1..8.
REQ-006 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 start  input  1  one-cycle start-round pulse.
REQ-010 hit_valid  input  1  one-cycle keyboard hit strobe.
REQ-011 hit_pos  input  4  hole index 0..8; values 9..15 are ignored.
REQ-012 map  output  9  bit i = mole up in hole i.
REQ-013 hit_ok  output  1  one-cycle pulse, hit landed on a mole.
REQ-014 hit_bad  output  1  one-cycle pulse, hit on an empty hole.
REQ-015 miss  output  1  one-cycle pulse, a mole expired unhit.
REQ-016 round_done  output  1  one-cycle pulse at round end.
REQ-017 state  output  2  00 IDLE, 01 RUN, 10 END.
REQ-018 time_left  output  12  ticks remaining in round.

Function
REQ-019 FSM: IDLE -start-> RUN; RUN -time_left reaches 0-> END; END -start-> RUN; start in RUN is ignored.
REQ-020 On entering RUN: tick divider, spawn counter, all life timers clear; time_left = ROUND_TICKS; map = 0.
REQ-021 Tick: in RUN only, divider counts 0..TICK_DIV-1; internal tick pulses on the wrap cycle.
REQ-022 Each tick in RUN: time_left decrements; the tick that takes it to 0 moves FSM to END and pulses round_done that same cycle.
REQ-023 In IDLE/END: map = 0, no spawns, hits ignored (no hit_ok/hit_bad), time_left holds.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset, advances every clk in all states, never all-zero.
REQ-025 Spawn attempt on every SPAWN_TICKS-th tick; attempt proceeds only if popcount(map) < MAX_ACTIVE, else skipped silently.
REQ-026 Candidate hole c = lfsr[3:0], minus 9 if >= 9; if hole c is occupied, take the first free hole scanning c+1, c+2, ... wrapping 8->0.
REQ-027 Spawned hole: map bit set next cycle, its life timer loaded with LIFE_TICKS.
REQ-028 Each tick, every occupied hole's life timer decrements; the decrement to 0 clears its map bit and pulses miss.
REQ-029 Multiple expiries on one tick produce a single miss pulse (team accepts this granularity).
REQ-030 hit_valid with valid hit_pos in RUN: occupied hole -> bit cleared, hit_ok next cycle; empty hole -> hit_bad next cycle.
REQ-031 Hit and expiry on the same hole in the same cycle: hit wins (hit_ok, no miss).
REQ-032 Spawn selection uses the map as of the start of the cycle; a hole freed by a hit or expiry in that cycle is not respawned in the same cycle.
REQ-033 All pulse outputs are registered, one cycle wide, and never asserted outside RUN except round_done.

Reset
REQ-034 rst asserted: state = IDLE, map = 0, all pulses 0, time_left = 0, counters and timers 0, LFSR = 16'hACE1, immediately and asynchronously.
REQ-035 rst mid-round aborts the round with no round_done or miss pulse.

Verification (TICK_DIV=4, SPAWN_TICKS=2, LIFE_TICKS=3, ROUND_TICKS=20, MAX_ACTIVE=2)
REQ-036 Reset, no start for 100 cycles -> state 00, map 0, no pulses.
REQ-037 start -> state 01, time_left 20; after 80 cycles round_done pulses once, state 10, map 0.
REQ-038 Let a mole live untouched -> bit clears exactly 3 ticks (12 cycles) after set, miss pulses once.
REQ-039 Hit an occupied hole -> hit_ok next cycle, bit cleared; hit an empty hole -> hit_bad only; hit_pos=12 -> no pulse.
REQ-040 Run the full round -> popcount(map) never exceeds 2; the forced occupied-candidate case lands on the next free hole with wrap 8->0.
REQ-041 Hit coinciding with that hole's expiry -> hit_ok, no miss; rst mid-round -> IDLE, no round_done.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game core (round timer, pseudo-random mole spawns, per-hole lifetimes, hit scoring).
// Latency: map and all pulse outputs are registered; a hit, tick or start shows its effect one clk later.
// Backpressure: none; hit strobes are taken every cycle in RUN and silently dropped in IDLE/END.
// Ports: clk/rst (async active-high), start (round start pulse), hit_valid/hit_pos (keyboard hit),
//        map (mole-up bitmap, 9 holes), hit_ok/hit_bad/miss/round_done (1-cycle pulses),
//        state (00 IDLE, 01 RUN, 10 END), time_left (ticks remaining in the round).
module mole_scheduler #(
  parameter int TICK_DIV    = 1000000,
  parameter int SPAWN_TICKS = 50,
  parameter int LIFE_TICKS  = 80,
  parameter int ROUND_TICKS = 3000,
  parameter int MAX_ACTIVE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit_valid,
  input  logic [3:0]  hit_pos,
  output logic [8:0]  map,
  output logic        hit_ok,
  output logic        hit_bad,
  output logic        miss,
  output logic        round_done,
  output logic [1:0]  state,
  output logic [11:0] time_left
);

  localparam int NHOLE = 9;
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int SPN_W = $clog2(SPAWN_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_END  = 2'b10
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [SPN_W-1:0] spn_q;
  logic [11:0]      time_left_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [8:0]       map_q;
  logic [8:0]       map_d;
  logic [7:0]       life_q [NHOLE];
  logic [7:0]       life_d [NHOLE];
  logic             hit_ok_q;
  logic             hit_bad_q;
  logic             miss_q;
  logic             round_done_q;

  logic             tick;
  logic             spawn_slot;
  logic             hit_acc;
  logic             spawn_go;
  logic             spawn_found;
  logic             hit_good;
  logic             hit_empty;
  logic             any_expire;
  logic [3:0]       pop;
  logic [3:0]       cand;
  logic [3:0]       spawn_hole;
  logic [4:0]       scan_idx;

  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign tick       = (state_q == S_RUN) && (div_q == DIV_W'(TICK_DIV - 1));
  assign spawn_slot = tick && (spn_q == SPN_W'(SPAWN_TICKS - 1));
  assign hit_acc    = hit_valid && (state_q == S_RUN) && (hit_pos < 4'd9);
  assign cand       = (lfsr_q[3:0] >= 4'd9) ? (lfsr_q[3:0] - 4'd9) : lfsr_q[3:0];

  // Occupancy count and spawn hole selection both look at the map as it
  // stands at the start of the cycle, so a hole freed this cycle is not reused.
  always_comb begin
    pop         = '0;
    spawn_found = 1'b0;
    spawn_hole  = '0;
    scan_idx    = '0;
    for (int i = 0; i < NHOLE; i++) begin
      pop = pop + {3'b000, map_q[i]};
    end
    for (int k = 0; k < NHOLE; k++) begin
      scan_idx = {1'b0, cand} + 5'(k);
      if (scan_idx >= 5'd9) begin
        scan_idx = scan_idx - 5'd9;
      end
      if (!spawn_found && !map_q[scan_idx[3:0]]) begin
        spawn_found = 1'b1;
        spawn_hole  = scan_idx[3:0];
      end
    end
  end

  assign spawn_go = spawn_slot && (pop < 4'(MAX_ACTIVE)) && spawn_found;

  // Per-hole update. A hit takes priority over that hole's expiry; only
  // empty holes can be spawned into.
  always_comb begin
    map_d      = map_q;
    hit_good   = 1'b0;
    hit_empty  = 1'b0;
    any_expire = 1'b0;
    for (int i = 0; i < NHOLE; i++) begin
      life_d[i] = life_q[i];
      if (map_q[i]) begin
        if (hit_acc && (hit_pos == 4'(i))) begin
          hit_good  = 1'b1;
          map_d[i]  = 1'b0;
          life_d[i] = '0;
        end else if (tick) begin
          life_d[i] = life_q[i] - 8'd1;
          if (life_q[i] == 8'd1) begin
            map_d[i]   = 1'b0;
            any_expire = 1'b1;
          end
        end
      end else begin
        if (hit_acc && (hit_pos == 4'(i))) begin
          hit_empty = 1'b1;
        end
        if (spawn_go && (spawn_hole == 4'(i))) begin
          map_d[i]  = 1'b1;
          life_d[i] = 8'(LIFE_TICKS);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      spn_q        <= '0;
      time_left_q  <= '0;
      lfsr_q       <= 16'hACE1;
      map_q        <= '0;
      hit_ok_q     <= 1'b0;
      hit_bad_q    <= 1'b0;
      miss_q       <= 1'b0;
      round_done_q <= 1'b0;
      for (int i = 0; i < NHOLE; i++) begin
        life_q[i] <= '0;
      end
    end else begin
      lfsr_q       <= lfsr_d;
      hit_ok_q     <= 1'b0;
      hit_bad_q    <= 1'b0;
      miss_q       <= 1'b0;
      round_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_END: begin
          if (start) begin
            state_q     <= S_RUN;
            div_q       <= '0;
            spn_q       <= '0;
            time_left_q <= 12'(ROUND_TICKS);
            map_q       <= '0;
            for (int i = 0; i < NHOLE; i++) begin
              life_q[i] <= '0;
            end
          end
        end
        S_RUN: begin
          map_q     <= map_d;
          life_q    <= life_d;
          hit_ok_q  <= hit_good;
          hit_bad_q <= hit_empty;
          miss_q    <= any_expire;
          if (tick) begin
            div_q       <= '0;
            spn_q       <= spawn_slot ? '0 : (spn_q + 1'b1);
            time_left_q <= time_left_q - 12'd1;
            // Final tick: round ends here, so everything else this cycle is
            // dropped to keep game pulses out of END.
            if (time_left_q == 12'd1) begin
              state_q      <= S_END;
              round_done_q <= 1'b1;
              map_q        <= '0;
              hit_ok_q     <= 1'b0;
              hit_bad_q    <= 1'b0;
              miss_q       <= 1'b0;
              for (int i = 0; i < NHOLE; i++) begin
                life_q[i] <= '0;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign map        = map_q;
  assign hit_ok     = hit_ok_q;
  assign hit_bad    = hit_bad_q;
  assign miss       = miss_q;
  assign round_done = round_done_q;
  assign state      = state_q;
  assign time_left  = time_left_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed bench for mole_scheduler with small game parameters.
// Latency: outputs sampled 1 ns after each rising edge (or mid-cycle for async reset).
// Backpressure: none; stimulus is driven cycle by cycle from the main initial block.
`timescale 1ns/1ps
module tb_mole_scheduler;

  localparam int TD = 4;
  localparam int ST = 2;
  localparam int LT = 3;
  localparam int RT = 20;
  localparam int MA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hit_valid;
  logic [3:0]  hit_pos;
  logic [8:0]  map;
  logic        hit_ok;
  logic        hit_bad;
  logic        miss;
  logic        round_done;
  logic [1:0]  state;
  logic [11:0] time_left;

  int total = 0;
  int bad   = 0;
  int rd_cnt    = 0;
  int over_cnt  = 0;
  int stray_cnt = 0;

  always #5 clk = ~clk;

  mole_scheduler #(
    .TICK_DIV   (TD),
    .SPAWN_TICKS(ST),
    .LIFE_TICKS (LT),
    .ROUND_TICKS(RT),
    .MAX_ACTIVE (MA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit_valid (hit_valid),
    .hit_pos   (hit_pos),
    .map       (map),
    .hit_ok    (hit_ok),
    .hit_bad   (hit_bad),
    .miss      (miss),
    .round_done(round_done),
    .state     (state),
    .time_left (time_left)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic int hole_of(input logic [15:0] v);
    int nib;
    nib = int'(v[3:0]);
    return (nib >= 9) ? nib - 9 : nib;
  endfunction

  // Reference LFSR: value during cycle j is visible here 1 ns after edge j.
  logic [15:0] ref_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= lfsr_step(ref_lfsr);
  end

  always @(negedge clk) begin
    if ($countones(map) > MA) over_cnt++;
    if (round_done) rd_cnt++;
    if ((state != 2'b01) && (hit_ok || hit_bad || miss)) stray_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int found;
    int c6;
    int c8;
    rst = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_pos = 4'd0;
    #2;
    chk("rst_state", state, 2'b00);
    chk("rst_map", map, 9'h000);
    chk("rst_time", time_left, 12'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle: a hit must be ignored, nothing happens for 100 cycles.
    hit_valid = 1'b1; hit_pos = 4'd3;
    step(1);
    hit_valid = 1'b0;
    step(99);
    chk("idle_state", state, 2'b00);
    chk("idle_map", map, 9'h000);
    chk("idle_pulses", stray_cnt + rd_cnt, 0);
    chk("idle_time", time_left, 12'd0);

    // Pick a start moment so the first two spawn candidates are both hole 8.
    found = 0;
    for (int w = 0; w < 20000 && found == 0; w++) begin
      if (hole_of(lfsr_adv(ref_lfsr, 8)) == 8 && hole_of(lfsr_adv(ref_lfsr, 16)) == 8) found = 1;
      else step(1);
    end
    chk("lfsr_search", found, 1);

    start = 1'b1;
    step(1);                                   // edge 0: enter RUN
    start = 1'b0;
    chk("run_state", state, 2'b01);
    chk("run_time", time_left, 12'd20);
    chk("run_map", map, 9'h000);
    step(7);                                   // edge 7
    chk("pre_spawn_map", map, 9'h000);
    chk("tick1_time", time_left, 12'd19);
    step(1);                                   // edge 8: tick 2 spawn at hole 8
    chk("spawn8_map", map, 9'h100);
    chk("tick2_time", time_left, 12'd18);
    step(8);                                   // edge 16: tick 4, candidate 8 busy -> wraps to 0
    chk("wrap_map", map, 9'h101);
    step(3);                                   // edge 19: 11 cycles after set, still up
    chk("life_hold_map", map, 9'h101);
    chk("life_hold_miss", miss, 1'b0);
    step(1);                                   // edge 20: 12 cycles after set, expires
    chk("expire_map", map, 9'h001);
    chk("expire_miss", miss, 1'b1);

    hit_valid = 1'b1; hit_pos = 4'd0;
    step(1);                                   // edge 21
    chk("miss_once", miss, 1'b0);
    chk("hit_ok", hit_ok, 1'b1);
    chk("hit_clear_map", map, 9'h000);
    hit_pos = 4'd5;
    step(1);                                   // edge 22
    chk("bad_ok", hit_ok, 1'b0);
    chk("bad_bad", hit_bad, 1'b1);
    hit_pos = 4'd12;
    step(1);                                   // edge 23
    chk("pos12_ok", hit_ok, 1'b0);
    chk("pos12_bad", hit_bad, 1'b0);
    hit_valid = 1'b0;
    c6 = hole_of(ref_lfsr);                    // tick 6 runs in cycle 23
    step(1);                                   // edge 24
    chk("spawn6_map", map, 32'(1) << c6);
    chk("pos12_late", hit_ok | hit_bad, 1'b0);
    step(7);                                   // edge 31
    c8 = hole_of(ref_lfsr);
    if (c8 == c6) c8 = (c6 + 1) % 9;
    step(1);                                   // edge 32: tick 8 spawn
    chk("spawn8t_map", map, (32'(1) << c6) | (32'(1) << c8));
    step(3);                                   // edge 35: c6 expires on tick 9 (cycle 35)
    hit_valid = 1'b1; hit_pos = 4'(c6);
    step(1);                                   // edge 36
    hit_valid = 1'b0;
    chk("race_ok", hit_ok, 1'b1);
    chk("race_miss", miss, 1'b0);
    chk("race_map", map, 32'(1) << c8);
    step(1);                                   // edge 37
    chk("race_miss_late", miss, 1'b0);
    step(42);                                  // edge 79
    chk("last_state", state, 2'b01);
    chk("last_time", time_left, 12'd1);
    step(1);                                   // edge 80: round ends
    chk("end_state", state, 2'b10);
    chk("end_done", round_done, 1'b1);
    chk("end_map", map, 9'h000);
    chk("end_time", time_left, 12'd0);
    hit_valid = 1'b1; hit_pos = 4'd0;
    step(1);                                   // edge 81
    hit_valid = 1'b0;
    chk("end_done_clr", round_done, 1'b0);
    chk("end_hit", hit_ok | hit_bad, 1'b0);
    chk("done_count", rd_cnt, 1);
    chk("max_active", over_cnt, 0);

    // Second round from END; a start inside RUN is ignored.
    start = 1'b1;
    step(1);                                   // edge 0'
    start = 1'b0;
    chk("r2_state", state, 2'b01);
    chk("r2_time", time_left, 12'd20);
    step(10);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);                                   // edge 12'
    chk("r2_restart_ign", time_left, 12'd17);
    step(18);
    rst = 1'b1;
    #1;
    chk("arst_state", state, 2'b00);
    chk("arst_map", map, 9'h000);
    chk("arst_time", time_left, 12'd0);
    chk("arst_pulses", {hit_ok, hit_bad, miss, round_done}, 4'h0);
    step(2);
    rst = 1'b0;
    step(100);
    chk("post_rst_state", state, 2'b00);
    chk("post_rst_done", rd_cnt, 1);
    chk("stray_pulses", stray_cnt, 0);
    chk("max_active_all", over_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
